// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      CHECK = 3'd2,
      BUSY  = 3'd3,
      DONE  = 3'd4
   } lsu_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

   // Natural alignment check on the low address bits for a given access size.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SIZE_WORD) && (addr_lo != 2'b00)) ||
             ((size == SIZE_HALF) && addr_lo[0]);
   endfunction

endpackage

// File: rtl/lsu_fault_encode.sv
// Combinational fault priority and mcause mapping for load/store completions.
module lsu_fault_encode
   import lsu_pkg::*;
(
   input  logic       is_store_i,
   input  logic       op_fault_i,
   input  logic       addr_fault_i,
   input  logic       access_fault_i,
   output logic       fault_o_c,
   output logic [3:0] cause_o_c
);

   always_comb begin
      fault_o_c = op_fault_i | addr_fault_i | access_fault_i;
      cause_o_c = 4'd0;
      if (op_fault_i) begin
         cause_o_c = CAUSE_ILLEGAL;
      end else if (addr_fault_i) begin
         cause_o_c = is_store_i ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
      end else if (access_fault_i) begin
         cause_o_c = is_store_i ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
      end
   end

endmodule

// File: rtl/lsu_sequencer.sv
// Single-outstanding load/store sequencer in front of the memory access unit.
// Optional local alignment/size precheck: define LSU_MISALIGN_PRECHECK_EN.
module lsu_sequencer
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_base,
   input  logic [XLEN-1:0] req_imm,
   input  logic [XLEN-1:0] req_wdata,
   output logic            mem_available,
   output logic            mem_is_write,
   output logic            mem_is_unsigned,
   output logic [1:0]      mem_op,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_in,
   input  logic [XLEN-1:0] mem_out,
   input  logic            mem_busy,
   input  logic            mem_op_fault,
   input  logic            mem_addr_fault,
   input  logic            mem_access_fault,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_fault,
   output logic [3:0]      rsp_cause,
   output logic [XLEN-1:0] rsp_tval
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

   lsu_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            req_ready_q, req_ready_d;
   logic            mem_available_q, mem_available_d;
   logic            mem_is_write_q, mem_is_write_d;
   logic            mem_is_unsigned_q, mem_is_unsigned_d;
   logic [1:0]      mem_op_q, mem_op_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] mem_in_q, mem_in_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
   logic            rsp_fault_q, rsp_fault_d;
   logic [3:0]      rsp_cause_q, rsp_cause_d;
   logic [XLEN-1:0] rsp_tval_q, rsp_tval_d;

   logic [XLEN-1:0] ea_c;
   logic            idle_c;
   logic            timeout_c;
   logic            pre_op_c;
   logic            pre_addr_c;
   logic            enc_store_c;
   logic            enc_op_c;
   logic            enc_addr_c;
   logic            enc_access_c;
   logic            enc_fault_c;
   logic [3:0]      enc_cause_c;
   logic            finish_c;

   assign ea_c   = req_base + req_imm;
   assign idle_c = (state_q == IDLE);

   assign timeout_c = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) && mem_busy &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_PRECHECK_EN
   assign pre_op_c   = (req_funct3[1:0] == 2'b11);
   assign pre_addr_c = is_misaligned(req_funct3[1:0], ea_c[1:0]);
`else
   assign pre_op_c   = 1'b0;
   assign pre_addr_c = 1'b0;
`endif

   // In IDLE the encoder judges the incoming request; afterwards, the memory's verdict.
   assign enc_store_c  = idle_c ? req_is_store : mem_is_write_q;
   assign enc_op_c     = idle_c ? pre_op_c     : mem_op_fault;
   assign enc_addr_c   = idle_c ? pre_addr_c   : mem_addr_fault;
   assign enc_access_c = idle_c ? 1'b0         : (mem_access_fault | timeout_c);

   lsu_fault_encode u_fault_encode (
      .is_store_i     (enc_store_c),
      .op_fault_i     (enc_op_c),
      .addr_fault_i   (enc_addr_c),
      .access_fault_i (enc_access_c),
      .fault_o_c      (enc_fault_c),
      .cause_o_c      (enc_cause_c)
   );

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      mem_is_write_d    = mem_is_write_q;
      mem_is_unsigned_d = mem_is_unsigned_q;
      mem_op_d          = mem_op_q;
      mem_addr_d        = mem_addr_q;
      mem_in_d          = mem_in_q;
      rsp_valid_d       = 1'b0;
      rsp_rdata_d       = '0;
      rsp_fault_d       = 1'b0;
      rsp_cause_d       = 4'd0;
      rsp_tval_d        = '0;
      finish_c          = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               mem_is_write_d    = req_is_store;
               mem_is_unsigned_d = req_funct3[2];
               mem_op_d          = req_funct3[1:0];
               mem_addr_d        = ea_c;
               mem_in_d          = req_wdata;
               state_d           = REQ;
               finish_c          = enc_fault_c;
            end
         end
         REQ:   state_d = CHECK;
         CHECK: begin
            if (mem_busy) begin
               state_d = BUSY;
               cnt_d   = '0;
            end else begin
               finish_c = 1'b1;
            end
         end
         BUSY: begin
            if (!mem_busy || timeout_c) begin
               finish_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Completion: one-cycle response built from the encoder and captured read data.
      if (finish_c) begin
         state_d     = DONE;
         rsp_valid_d = 1'b1;
         rsp_fault_d = enc_fault_c;
         if (enc_fault_c) begin
            rsp_cause_d = enc_cause_c;
            rsp_tval_d  = idle_c ? ea_c : mem_addr_q;
         end else if (!mem_is_write_q) begin
            rsp_rdata_d = mem_out;
         end
      end

      mem_available_d = (state_d == REQ) || (state_d == CHECK) || (state_d == BUSY);
      req_ready_d     = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= IDLE;
         cnt_q             <= '0;
         req_ready_q       <= 1'b1;
         mem_available_q   <= 1'b0;
         mem_is_write_q    <= 1'b0;
         mem_is_unsigned_q <= 1'b0;
         mem_op_q          <= 2'b00;
         mem_addr_q        <= '0;
         mem_in_q          <= '0;
         rsp_valid_q       <= 1'b0;
         rsp_rdata_q       <= '0;
         rsp_fault_q       <= 1'b0;
         rsp_cause_q       <= 4'd0;
         rsp_tval_q        <= '0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         req_ready_q       <= req_ready_d;
         mem_available_q   <= mem_available_d;
         mem_is_write_q    <= mem_is_write_d;
         mem_is_unsigned_q <= mem_is_unsigned_d;
         mem_op_q          <= mem_op_d;
         mem_addr_q        <= mem_addr_d;
         mem_in_q          <= mem_in_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_rdata_q       <= rsp_rdata_d;
         rsp_fault_q       <= rsp_fault_d;
         rsp_cause_q       <= rsp_cause_d;
         rsp_tval_q        <= rsp_tval_d;
      end
   end

   assign req_ready       = req_ready_q;
   assign mem_available   = mem_available_q;
   assign mem_is_write    = mem_is_write_q;
   assign mem_is_unsigned = mem_is_unsigned_q;
   assign mem_op          = mem_op_q;
   assign mem_addr        = mem_addr_q;
   assign mem_in          = mem_in_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_fault       = rsp_fault_q;
   assign rsp_cause       = rsp_cause_q;
   assign rsp_tval        = rsp_tval_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer with a cycle-level memory unit model.
module tb_lsu_sequencer;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
      logic [3:0]  cause;
      logic [31:0] tval;
   } rsp_t;

   logic        clk, reset;
   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_base, req_imm, req_wdata;
   logic        mem_available, mem_is_write, mem_is_unsigned;
   logic [1:0]  mem_op;
   logic [31:0] mem_addr, mem_in, mem_out;
   logic        mem_busy, mem_op_fault, mem_addr_fault, mem_access_fault;
   logic        rsp_valid, rsp_fault;
   logic [31:0] rsp_rdata, rsp_tval;
   logic [3:0]  rsp_cause;

   int          n_cmp = 0;
   int          n_err = 0;
   rsp_t        sb[$];

   // Memory model configuration and expected request fields.
   int          m_lat = 0;
   logic        m_stuck = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        m_op_f = 1'b0, m_addr_f = 1'b0, m_acc_f = 1'b0;
   logic [31:0] exp_addr = '0, exp_in = '0;
   logic [1:0]  exp_op = '0;
   logic        exp_write = 1'b0, exp_unsigned = 1'b0;
   logic        saw_avail = 1'b0;
   int          acnt = 0;

   lsu_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_is_store     (req_is_store),
      .req_funct3       (req_funct3),
      .req_base         (req_base),
      .req_imm          (req_imm),
      .req_wdata        (req_wdata),
      .mem_available    (mem_available),
      .mem_is_write     (mem_is_write),
      .mem_is_unsigned  (mem_is_unsigned),
      .mem_op           (mem_op),
      .mem_addr         (mem_addr),
      .mem_in           (mem_in),
      .mem_out          (mem_out),
      .mem_busy         (mem_busy),
      .mem_op_fault     (mem_op_fault),
      .mem_addr_fault   (mem_addr_fault),
      .mem_access_fault (mem_access_fault),
      .rsp_valid        (rsp_valid),
      .rsp_rdata        (rsp_rdata),
      .rsp_fault        (rsp_fault),
      .rsp_cause        (rsp_cause),
      .rsp_tval         (rsp_tval)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory unit model plus request-stability check while the access is offered.
   always @(negedge clk) begin
      if (reset || !mem_available) begin
         acnt = 0;
         mem_busy = 1'b0; mem_op_fault = 1'b0; mem_addr_fault = 1'b0;
         mem_access_fault = 1'b0; mem_out = '0;
      end else begin
         saw_avail = 1'b1;
         acnt++;
         n_cmp++;
         if ({mem_addr, mem_in, mem_op, mem_is_write, mem_is_unsigned} !==
             {exp_addr, exp_in, exp_op, exp_write, exp_unsigned}) begin
            n_err++;
            $display("FAIL mem_req_stable: got addr=%h in=%h op=%0d wr=%0d uns=%0d, required addr=%h in=%h op=%0d wr=%0d uns=%0d",
                     mem_addr, mem_in, mem_op, mem_is_write, mem_is_unsigned,
                     exp_addr, exp_in, exp_op, exp_write, exp_unsigned);
         end
         if (acnt >= 2 && (m_stuck || acnt < 2 + m_lat)) begin
            mem_busy = 1'b1; mem_op_fault = 1'b0; mem_addr_fault = 1'b0;
            mem_access_fault = 1'b0; mem_out = '0;
         end else if (acnt >= 2) begin
            mem_busy = 1'b0; mem_op_fault = m_op_f; mem_addr_fault = m_addr_f;
            mem_access_fault = m_acc_f; mem_out = m_rdata;
         end else begin
            mem_busy = 1'b0; mem_op_fault = 1'b0; mem_addr_fault = 1'b0;
            mem_access_fault = 1'b0; mem_out = '0;
         end
      end
   end

   // Scoreboard: every completion pops one expected response.
   always @(negedge clk) begin
      if (!reset && rsp_valid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 cause=%0d tval=%h, required no response",
                     rsp_cause, rsp_tval);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            if ({rsp_rdata, rsp_fault, rsp_cause, rsp_tval} !== e) begin
               n_err++;
               $display("FAIL rsp: got rdata=%h fault=%0d cause=%0d tval=%h, required rdata=%h fault=%0d cause=%0d tval=%h",
                        rsp_rdata, rsp_fault, rsp_cause, rsp_tval, e.rdata, e.fault, e.cause, e.tval);
            end
         end
      end
   end

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] wdata);
      int w;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL req_ready_wait: got req_ready=0, required 1 within 50 cycles");
      end
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_base = base; req_imm = imm; req_wdata = wdata;
      exp_addr = base + imm; exp_in = wdata; exp_op = f3[1:0];
      exp_write = st; exp_unsigned = f3[2];
      saw_avail = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) req_valid = 1'b0;
      end while (!rsp_valid && cyc < 200);
      if (!rsp_valid) begin
         n_cmp++; n_err++;
         $display("FAIL rsp_timeout: got no rsp_valid, required one within 200 cycles");
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rsp_pulse_width: got rsp_valid=%0d one cycle later, required 0", rsp_valid);
      end
   endtask

   task automatic set_mem(input int lat, input logic stuck, input logic [31:0] rd,
                          input logic opf, input logic adf, input logic acf);
      m_lat = lat; m_stuck = stuck; m_rdata = rd;
      m_op_f = opf; m_addr_f = adf; m_acc_f = acf;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({req_ready, mem_available, mem_is_write, mem_op, mem_addr, rsp_valid, rsp_fault,
           rsp_cause, rsp_tval, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0,
           4'd0, 32'h0, 32'h0}) begin
         n_err++;
         $display("FAIL reset_outputs: got ready=%0d avail=%0d addr=%h rsp_valid=%0d cause=%0d, required ready=1 rest 0",
                  req_ready, mem_available, mem_addr, rsp_valid, rsp_cause);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || mem_available !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: got ready=%0d avail=%0d, required 1/0", req_ready, mem_available);
      end
   endtask

   task automatic test_word_load;
      int cyc;
      set_mem(3, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 3'b010, 32'h1000, 32'h4, 32'h0);
      sb.push_back('{32'hDEADBEEF, 1'b0, 4'd0, 32'h0});
      wait_rsp(cyc);
      n_cmp++;
      if (cyc !== 6) begin
         n_err++;
         $display("FAIL word_load_latency: got %0d cycles, required 6", cyc);
      end
   endtask

   task automatic test_store_fault;
      int cyc;
      set_mem(0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      issue(1'b1, 3'b001, 32'h2000, 32'h1, 32'hA5A5);
      sb.push_back('{32'h0, 1'b1, 4'd6, 32'h2001});
      wait_rsp(cyc);
   endtask

   task automatic test_op_fault;
      int cyc;
      set_mem(0, 1'b0, 32'h77777777, 1'b1, 1'b1, 1'b1);
      issue(1'b0, 3'b011, 32'h100, 32'h10, 32'h0);
      sb.push_back('{32'h0, 1'b1, 4'd2, 32'h110});
      wait_rsp(cyc);
   endtask

   task automatic test_setup_fail;
      int cyc;
      set_mem(0, 1'b0, 32'h12121212, 1'b0, 1'b0, 1'b1);
      issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0);
      sb.push_back('{32'h0, 1'b1, 4'd5, 32'h40});
      wait_rsp(cyc);
      n_cmp++;
      if (cyc !== 3) begin
         n_err++;
         $display("FAIL setup_fail_latency: got %0d cycles after accept, required 3", cyc);
      end
   endtask

   task automatic test_timeout;
      int cyc;
      set_mem(0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 3'b010, 32'h80, 32'h0, 32'h0);
      sb.push_back('{32'h0, 1'b1, 4'd5, 32'h80});
      wait_rsp(cyc);
      n_cmp++;
      if (cyc !== 11) begin
         n_err++;
         $display("FAIL timeout_latency: got %0d cycles, required 11", cyc);
      end
      issue(1'b1, 3'b010, 32'h90, 32'h4, 32'hBEEF);
      sb.push_back('{32'h0, 1'b1, 4'd7, 32'h94});
      wait_rsp(cyc);
      set_mem(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_busy;
      set_mem(0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 3'b010, 32'hC0, 32'h0, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if (mem_available !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_busy: got avail=%0d ready=%0d rsp_valid=%0d, required 0/1/0",
                  mem_available, req_ready, rsp_valid);
      end
      set_mem(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (12) @(negedge clk);
   endtask

   task automatic test_wrap;
      int cyc;
      set_mem(1, 1'b0, 32'h0000005A, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 3'b100, 32'hFFFFFFFC, 32'h8, 32'h0);
      n_cmp++;
      if (exp_addr !== 32'h4) begin
         n_err++;
         $display("FAIL wrap_model: got %h, required 00000004", exp_addr);
      end
      sb.push_back('{32'h0000005A, 1'b0, 4'd0, 32'h0});
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem_addr !== 32'h00000004 || mem_available !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_addr: got addr=%h avail=%0d, required 00000004/1", mem_addr, mem_available);
      end
      wait_rsp(cyc);
   endtask

   task automatic test_store_ok;
      int cyc;
      set_mem(2, 1'b0, 32'hFFFF0000, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 3'b010, 32'h200, 32'h0, 32'h12345678);
      sb.push_back('{32'h0, 1'b0, 4'd0, 32'h0});
      wait_rsp(cyc);
   endtask

   task automatic test_back_to_back;
      int t, cyc;
      set_mem(0, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
      sb.push_back('{32'h11111111, 1'b0, 4'd0, 32'h0});
      @(negedge clk);
      t = 1;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ready_while_active: got %0d, required 0", req_ready);
      end
      req_base = 32'h400;
      while (!req_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (t !== 4) begin
         n_err++;
         $display("FAIL back_to_back_spacing: got %0d cycles, required 4", t);
      end
      exp_addr = 32'h400;
      m_rdata = 32'h22222222;
      sb.push_back('{32'h22222222, 1'b0, 4'd0, 32'h0});
      wait_rsp(cyc);
   endtask

   task automatic test_precheck;
      int cyc;
      set_mem(0, 1'b0, 32'hCAFE0003, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 3'b010, 32'h0, 32'h3, 32'h0);
`ifdef LSU_MISALIGN_PRECHECK_EN
      sb.push_back('{32'h0, 1'b1, 4'd4, 32'h3});
      wait_rsp(cyc);
      n_cmp++;
      if (saw_avail !== 1'b0 || cyc !== 1) begin
         n_err++;
         $display("FAIL precheck_local: got avail_seen=%0d cycles=%0d, required 0/1", saw_avail, cyc);
      end
`else
      sb.push_back('{32'hCAFE0003, 1'b0, 4'd0, 32'h0});
      wait_rsp(cyc);
      n_cmp++;
      if (saw_avail !== 1'b1) begin
         n_err++;
         $display("FAIL precheck_off_forward: got avail_seen=%0d, required 1", saw_avail);
      end
`endif
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
      req_base = '0; req_imm = '0; req_wdata = '0;
      @(negedge clk);
      test_reset;
      test_word_load;
      test_store_fault;
      test_op_fault;
      test_setup_fail;
      test_timeout;
      test_reset_busy;
      test_wrap;
      test_store_ok;
      test_back_to_back;
      test_precheck;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
